// File: rtl/tx_credit_counter.sv
// -----------------------------------------------------------------------------
// tx_credit_counter
//
// Transmit-side credit tracker. The far-end receiver buffers words in an
// occupancy counter, and this block mirrors how much room is left there. Once
// the link comes up it loads MAX_CREDITS. Each accepted transmit handshake
// spends one credit, and the receiver hands credits back on cred_ret. tx_ready
// is withheld whenever a send could overflow the far-end buffer.
//
// Optional feature macro: CREDIT_BYPASS_EN
//   Undefined (default): tx_ready is a decode of registered state only. A
//       credit returned while the count is zero becomes usable next cycle.
//   Defined: while ACTIVE, a credit returned this cycle can be spent in the
//       same cycle. This adds a combinational path cred_ret -> tx_ready.
//
// Parameters
//   NBITS        credit counter width
//   MAX_CREDITS  credits loaded at link-up, legal range 1 .. 2**NBITS-1
//   RET_W        width of the per-cycle credit return count
//
// Ports
//   CLK       in   clock
//   RST       in   asynchronous active-high reset
//   link_up   in   level: link trained and receiver buffer empty
//   tx_valid  in   upstream has a word to send
//   tx_ready  out  a send would be accepted this cycle
//   cred_ret  in   credits returned this cycle
//   err_clr   in   single-cycle pulse that leaves ERROR
//   credits   out  current credit count (registered)
//   empty     out  credits == 0
//   full      out  credits == MAX_CREDITS
//   ovf_err   out  sticky: receiver returned more credits than exist
//   state_o   out  INIT=0, ACTIVE=1, ERROR=2
//
// States
//   state  | meaning
//   INIT   | link down or recovering; credits held at 0, returns ignored
//   ACTIVE | link up; sends spend credits, returns refill them
//   ERROR  | over-return seen; credits frozen until err_clr
// -----------------------------------------------------------------------------
module tx_credit_counter #(
    parameter int NBITS       = 4,
    parameter int MAX_CREDITS = 15,
    parameter int RET_W       = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             link_up,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [RET_W-1:0] cred_ret,
    input  logic             err_clr,
    output logic [NBITS-1:0] credits,
    output logic             empty,
    output logic             full,
    output logic             ovf_err,
    output logic [1:0]       state_o
);

    // The sum is one bit wider than credits + cred_ret so it cannot wrap.
    localparam int SW = NBITS + RET_W + 1;

    localparam logic [NBITS-1:0] MAX_N  = NBITS'(MAX_CREDITS);
    localparam logic [SW-1:0]    MAX_SW = SW'(MAX_CREDITS);

    generate
        if (MAX_CREDITS < 1 || MAX_CREDITS > (2 ** NBITS) - 1) begin : g_bad_max
            $error("tx_credit_counter: MAX_CREDITS=%0d outside 1..%0d",
                   MAX_CREDITS, (2 ** NBITS) - 1);
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERROR  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [NBITS-1:0]  r_credits;
    logic [NBITS-1:0]  w_credits_nxt;
    logic              r_ovf_err;
    logic              w_ovf_nxt;

    logic              w_active;
    logic              w_send;
    logic [SW-1:0]     w_sum;
    logic              w_over;

    // -------------------------------------------------------------------------
    // State register (state, credit count, sticky overflow flag)
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_INIT;
            r_credits <= '0;
            r_ovf_err <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_credits <= w_credits_nxt;
            r_ovf_err <= w_ovf_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state / next-count logic
    // -------------------------------------------------------------------------
    assign w_send = tx_valid && tx_ready;

    // Add before subtracting. A send at zero credits is only possible in the
    // bypass build, and then cred_ret is nonzero, so the result never goes
    // negative.
    assign w_sum  = SW'(r_credits) + SW'(cred_ret) - SW'(w_send);
    assign w_over = (w_sum > MAX_SW);

    always_comb begin
        w_next_state  = r_state;
        w_credits_nxt = r_credits;
        w_ovf_nxt     = r_ovf_err;

        unique case (r_state)
            ST_INIT: begin
                w_credits_nxt = '0;
                if (link_up) begin
                    w_next_state  = ST_ACTIVE;
                    w_credits_nxt = MAX_N;
                end
            end

            ST_ACTIVE: begin
                // Link loss wins over any send/return in the same cycle. The
                // receiver buffer restarts empty when the link retrains.
                if (!link_up) begin
                    w_next_state  = ST_INIT;
                    w_credits_nxt = '0;
                end else if (w_over) begin
                    w_next_state  = ST_ERROR;
                    w_credits_nxt = MAX_N;
                    w_ovf_nxt     = 1'b1;
                end else begin
                    w_credits_nxt = w_sum[NBITS-1:0];
                end
            end

            ST_ERROR: begin
                // Only err_clr leaves ERROR. A link drop alone is not enough,
                // so software must acknowledge the overflow.
                if (err_clr) begin
                    w_next_state  = ST_INIT;
                    w_credits_nxt = '0;
                    w_ovf_nxt     = 1'b0;
                end
            end

            default: begin
                w_next_state  = ST_INIT;
                w_credits_nxt = '0;
                w_ovf_nxt     = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_active = (r_state == ST_ACTIVE);
`ifdef CREDIT_BYPASS_EN
        tx_ready = w_active && ((r_credits != '0) || (cred_ret != '0));
`else
        tx_ready = w_active && (r_credits != '0);
`endif
        credits  = r_credits;
        empty    = (r_credits == '0);
        full     = (r_credits == MAX_N);
        ovf_err  = r_ovf_err;
        state_o  = r_state;
    end

endmodule

// File: tb/tb_tx_credit_counter.sv
module tb_tx_credit_counter;

    localparam int NBITS = 4;
    localparam int MAXC  = 15;
    localparam int RET_W = 2;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             link_up = 1'b0;
    logic             tx_valid = 1'b0;
    logic             tx_ready;
    logic [RET_W-1:0] cred_ret = '0;
    logic             err_clr = 1'b0;
    logic [NBITS-1:0] credits;
    logic             empty;
    logic             full;
    logic             ovf_err;
    logic [1:0]       state_o;

    tx_credit_counter #(.NBITS(NBITS), .MAX_CREDITS(MAXC), .RET_W(RET_W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .link_up  (link_up),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .cred_ret (cred_ret),
        .err_clr  (err_clr),
        .credits  (credits),
        .empty    (empty),
        .full     (full),
        .ovf_err  (ovf_err),
        .state_o  (state_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int due;   // cycle whose negedge shows this result
        int cred;
        int st;
        int ovf;
        int rdy;   // -1: tx_ready not checked
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    event ev_async;

    always @(posedge CLK) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares every expectation that has come due.
    always @(negedge CLK or ev_async) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            chk("credits", int'(credits), mon_e.cred);
            chk("state_o", int'(state_o), mon_e.st);
            chk("ovf_err", int'(ovf_err), mon_e.ovf);
            chk("empty",   int'(empty),   (mon_e.cred == 0) ? 1 : 0);
            chk("full",    int'(full),    (mon_e.cred == MAXC) ? 1 : 0);
            if (mon_e.rdy >= 0) chk("tx_ready", int'(tx_ready), mon_e.rdy);
        end
    end

    function automatic exp_t mk(input int due, input int c, input int s, input int o, input int r);
        exp_t e;
        e.due = due; e.cred = c; e.st = s; e.ovf = o; e.rdy = r;
        return e;
    endfunction

    // Apply one cycle of inputs; the expected values are those after the edge.
    task automatic step(input logic lu, input logic tv, input int cr, input logic ec,
                        input int ec_cred, input int ec_st, input int ec_ovf, input int ec_rdy);
        link_up  = lu;
        tx_valid = tv;
        cred_ret = RET_W'(cr);
        err_clr  = ec;
        sb.push_back(mk(cyc + 1, ec_cred, ec_st, ec_ovf, ec_rdy));
        @(posedge CLK);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        // Reset values while RST is held.
        sb.push_back(mk(cyc, 0, 0, 0, 0));
        @(negedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Link down for 3 cycles: nothing moves.
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
        // Link up: full load.
        step(1, 0, 0, 0, 15, 1, 0, 1);
        // Drain with tx_valid held.
        for (int i = 1; i <= 15; i++) step(1, 1, 0, 0, 15 - i, 1, 0, (i == 15) ? 0 : 1);
        // tx_valid at zero credits: no send.
        step(1, 1, 0, 0, 0, 1, 0, 0);

        // Zero-credit return.
`ifdef CREDIT_BYPASS_EN
        step(1, 1, 1, 0, 0, 1, 0, -1);
`else
        step(1, 1, 1, 0, 1, 1, 0, 1);
        step(1, 1, 0, 0, 0, 1, 0, 0);
`endif

        // Refill to 5, then simultaneous send and return.
        step(1, 0, 3, 0, 3, 1, 0, 1);
        step(1, 0, 2, 0, 5, 1, 0, 1);
        step(1, 1, 2, 0, 6, 1, 0, 1);
        step(1, 1, 0, 0, 5, 1, 0, 1);
        step(1, 1, 1, 0, 5, 1, 0, 1);
        step(1, 0, 3, 0, 8, 1, 0, 1);

        // Up to 14, then over-return.
        step(1, 0, 3, 0, 11, 1, 0, 1);
        step(1, 0, 3, 0, 14, 1, 0, 1);
        step(1, 0, 3, 0, 15, 2, 1, 0);
        step(1, 0, 1, 0, 15, 2, 1, 0);
        step(0, 0, 0, 0, 15, 2, 1, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 15, 1, 0, 1);

        // Return up to exactly MAX is legal.
        step(1, 1, 0, 0, 14, 1, 0, 1);
        step(1, 0, 1, 0, 15, 1, 0, 1);

        // Link drop mid-traffic at 7 credits.
        for (int i = 1; i <= 8; i++) step(1, 1, 0, 0, 15 - i, 1, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 15, 1, 0, 1);

        // Async reset at 9 credits, checked before the next edge.
        for (int i = 1; i <= 6; i++) step(1, 1, 0, 0, 15 - i, 1, 0, 1);
        tx_valid = 1'b0;
        @(negedge CLK);
        #1;
        RST = 1'b1;
        #1;
        sb.push_back(mk(cyc, 0, 0, 0, 0));
        -> ev_async;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        step(1, 0, 0, 0, 15, 1, 0, 1);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge CLK);
        #1;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: actual=%0d pending required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: actual=%0d cycles required=finish", cyc);
        $fatal(1);
    end

endmodule

// File: doc/tx_credit_counter.md
Name: tx_credit_counter

Overview:
- Transmit-side credit tracker for the link whose receive side counts buffered entries with an inc/dec occupancy counter.
- Starts with MAX_CREDITS once the link comes up, spends one credit per accepted transmit handshake, and regains credits from the receiver's return bus.
- Gates tx_ready so the far-end buffer can never overflow.
- Sits between the upstream tx source and the encoder.

Parameters:
- NBITS, 4, credit counter width.
- MAX_CREDITS, 15, credits loaded at link-up; legal range 1..2**NBITS-1 (elaboration $error outside this range).
- RET_W, 2, width of the per-cycle credit return count.

Ports:
- CLK  input  1  clock.
- RST  input  1  asynchronous active-high reset.
- link_up  input  1  level; link trained and receiver buffer empty.
- tx_valid  input  1  upstream has a word to send.
- tx_ready  output  1  a credit is available and the block is in ACTIVE.
- cred_ret  input  RET_W  credits returned this cycle (0..2**RET_W-1).
- err_clr  input  1  single-cycle pulse; clears ERROR.
- credits  output  NBITS  current credit count (registered).
- empty  output  1  credits == 0.
- full  output  1  credits == MAX_CREDITS.
- ovf_err  output  1  sticky; credits returned beyond MAX_CREDITS.
- state_o  output  2  INIT=0, ACTIVE=1, ERROR=2.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is CLK, reset port is RST.
- Reset values: state=INIT, credits=0, ovf_err=0, tx_ready=0, empty=1, full=0.
- send = tx_valid && tx_ready. Only a send consumes a credit.
- INIT:
  - credits held at 0, tx_ready=0, cred_ret ignored.
  - link_up=1 → next cycle credits=MAX_CREDITS, state=ACTIVE.
- ACTIVE:
  - Without CREDIT_BYPASS_EN, tx_ready = (credits != 0).
  - Next count: sum = credits - send + cred_ret, computed at NBITS+RET_W+1 bits, no wrap.
  - sum <= MAX_CREDITS → credits <= sum.
  - sum > MAX_CREDITS → credits <= MAX_CREDITS, ovf_err <= 1, state <= ERROR.
  - send and return in the same cycle are both honoured; e.g. credits=3, send, cred_ret=1 → credits=3.
  - credits never underflows: send requires credits != 0, except under the optional feature below.
  - link_up=0 → next cycle state=INIT, credits=0. This takes priority over send/return in that cycle; a send handshake in that cycle still completes upstream.
- ERROR:
  - tx_ready=0, credits frozen, cred_ret ignored.
  - err_clr=1 → state=INIT, credits=0, ovf_err=0.
  - link_up=0 alone does not leave ERROR.
- Outputs are combinational decodes of registered state/credits (empty, full, tx_ready); latency from any input to the credits update is 1 cycle.
- RST mid-operation: immediate return to reset values, regardless of state or in-flight handshake.

Optional Feature:
- Macro: CREDIT_BYPASS_EN.
- Defined:
  - In ACTIVE, tx_ready = (credits != 0) || (cred_ret != 0).
  - A credit returned in the same cycle can be spent at credits=0; e.g. credits=0, cred_ret=1, send → credits stays 0.
  - Adds a combinational path cred_ret→tx_ready.
- Not defined:
  - tx_ready depends on registered state only.
  - At credits=0 a return becomes usable the following cycle.

Test Plan:
- Link-up and drain: RST, hold link_up=0 for 3 cycles → tx_ready=0, credits=0. Raise link_up → next cycle credits=15, full=1. Hold tx_valid=1 for 15 cycles, cred_ret=0 → credits steps 14..0, empty=1, tx_ready=0 at credits=0.
- Simultaneous send and return: credits=5, send, cred_ret=2 → credits=6. Then credits=5, send, cred_ret=1 → credits=5. Then credits=5, no send, cred_ret=3 → credits=8.
- Over-return: credits=14, cred_ret=3, no send → credits=15, ovf_err=1, state_o=2, tx_ready=0. Then cred_ret=1 → credits stays 15. Then err_clr → state_o=0, credits=0, ovf_err=0.
- Link drop mid-traffic: credits=7, tx_valid=1, link_up falls → next cycle state_o=0, credits=0, tx_ready=0. Raise link_up → credits=15.
- Zero-credit return: credits=0, tx_valid=1, cred_ret=1.
  - Without CREDIT_BYPASS_EN: no send that cycle, credits=1 next cycle, send the cycle after, credits=0.
  - With CREDIT_BYPASS_EN: send in the same cycle, credits=0.
- Async reset: assert RST between clock edges while ACTIVE with credits=9 → credits=0, state_o=0, tx_ready=0 before the next edge.
